// File: rtl/mul_hilo_if.sv
// Operand/control/result bus between the HI/LO issue unit and the Multiplier.
interface mul_hilo_if;
  logic [3:0]  mul_ctrl;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_r;
  logic        mul_valid;

  modport master (output mul_ctrl, mul_a, mul_b, input mul_r, mul_valid);
  modport slave  (input mul_ctrl, mul_a, mul_b, output mul_r, mul_valid);
endinterface

// File: rtl/mul_hilo_unit.sv
// Issues multiplies to the Multiplier, captures the product into HI/LO, serves
// mfhi/mflo/mthi/mtlo, stalls the pipeline while busy and flags product timeouts.
module mul_hilo_unit #(
  parameter logic [3:0]  MUL_OP  = 4'b1000,
  parameter logic [3:0]  IDLE_OP = 4'b0000,
  parameter int unsigned MIN_LAT = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mul_req_i,
  input  logic [15:0]       op_a_i,
  input  logic [15:0]       op_b_i,
  mul_hilo_if.master        mul_bus,
  input  logic              rd_en_i,
  input  logic              rd_sel_i,
  output logic [15:0]       rd_data_o,
  input  logic              wr_hi_i,
  input  logic              wr_lo_i,
  input  logic [15:0]       wr_data_i,
  output logic [15:0]       hi_o,
  output logic [15:0]       lo_o,
  output logic              busy_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAUNCH_END = CNT_W'(MIN_LAT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      hi_q;
  logic [15:0]      lo_q;
  logic [15:0]      mul_a_q;
  logic [15:0]      mul_b_q;
  logic [3:0]       mul_ctrl_q;
  logic             err_q;

  // Stale validity is masked during LAUNCH; product or timeout accepted in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_ctrl_q <= IDLE_OP;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_hi_i) hi_q <= wr_data_i;
          if (wr_lo_i) lo_q <= wr_data_i;
          if (mul_req_i) begin
            mul_a_q    <= op_a_i;
            mul_b_q    <= op_b_i;
            mul_ctrl_q <= MUL_OP;
            cnt_q      <= '0;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAUNCH_END) state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_bus.mul_valid) begin
            hi_q       <= mul_bus.mul_r[31:16];
            lo_q       <= mul_bus.mul_r[15:0];
            mul_ctrl_q <= IDLE_OP;
            state_q    <= IDLE;
          end else if (cnt_q == TIMEOUT_END) begin
            err_q      <= 1'b1;
            mul_ctrl_q <= IDLE_OP;
            state_q    <= IDLE;
          end
        end
        default: begin
          mul_ctrl_q <= IDLE_OP;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign mul_bus.mul_ctrl = mul_ctrl_q;
  assign mul_bus.mul_a    = mul_a_q;
  assign mul_bus.mul_b    = mul_b_q;

  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != IDLE);
  assign stall_o   = busy_o & (mul_req_i | rd_en_i | wr_hi_i | wr_lo_i);
  assign rd_data_o = rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed-vector bench for mul_hilo_unit with the Multiplier side driven by hand.
module tb_mul_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_req;
  logic [15:0] op_a, op_b;
  logic        rd_en, rd_sel;
  logic [15:0] rd_data;
  logic        wr_hi, wr_lo;
  logic [15:0] wr_data;
  logic [15:0] hi, lo;
  logic        busy, stall, err;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  int          n;

  mul_hilo_if bus ();

  mul_hilo_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_req_i (mul_req),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .mul_bus   (bus),
    .rd_en_i   (rd_en),
    .rd_sel_i  (rd_sel),
    .rd_data_o (rd_data),
    .wr_hi_i   (wr_hi),
    .wr_lo_i   (wr_lo),
    .wr_data_i (wr_data),
    .hi_o      (hi),
    .lo_o      (lo),
    .busy_o    (busy),
    .stall_o   (stall),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    op_a    = a;
    op_b    = b;
    mul_req = 1'b1;
    step();
    mul_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int cyc);
    cyc = 0;
    while (busy && cyc < max_cyc) begin
      step();
      cyc++;
    end
    chk("idle_bound", 32'(busy), 32'd0);
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] r);
    int c;
    launch(a, b);
    bus.mul_r     = r;
    bus.mul_valid = 1'b1;
    wait_idle(20, c);
    bus.mul_valid = 1'b0;
    chk("min_latency", 32'(c), 32'd3);
    chk("prod_hi", 32'(hi), 32'(r[31:16]));
    chk("prod_lo", 32'(lo), 32'(r[15:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mul_req = 1'b0; op_a = '0; op_b = '0;
    rd_en = 1'b0; rd_sel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    bus.mul_r = '0; bus.mul_valid = 1'b0;

    // Reset values
    #12;
    mul_req = 1'b1;
    #1;
    chk("rst_hi", 32'(hi), 32'd0);
    chk("rst_lo", 32'(lo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ctrl", 32'(bus.mul_ctrl), 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    mul_req = 1'b0;
    #5 rst_n = 1'b1;
    step();

    // 1: 21845*1 with a read stalled behind it
    launch(16'd21845, 16'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ctrl", 32'(bus.mul_ctrl), 32'h8);
    chk("t1_mul_a", 32'(bus.mul_a), 32'h5555);
    chk("t1_mul_b", 32'(bus.mul_b), 32'h0001);
    rd_en = 1'b1; rd_sel = 1'b0;
    #1;
    chk("t1_stall_rd", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_busy_wait", 32'(busy), 32'd1);
      chk("t1_ctrl_wait", 32'(bus.mul_ctrl), 32'h8);
    end
    bus.mul_r = 32'h0000_5555; bus.mul_valid = 1'b1;
    #1;
    chk("t1_rd_old", 32'(rd_data), 32'h0000);
    chk("t1_stall_cap", 32'(stall), 32'd1);
    step();
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_hi", 32'(hi), 32'h0000);
    chk("t1_lo", 32'(lo), 32'h5555);
    chk("t1_ctrl_idle", 32'(bus.mul_ctrl), 32'h0);
    chk("t1_stall_free", 32'(stall), 32'd0);
    chk("t1_rd_new", 32'(rd_data), 32'h5555);
    rd_en = 1'b0;

    // 2: back-to-back with stale valid still high
    bus.mul_r = 32'hDEAD_BEEF;
    launch(16'd1, 16'd21845);
    chk("t2_mul_a", 32'(bus.mul_a), 32'h0001);
    step();
    chk("t2_busy_e1", 32'(busy), 32'd1);
    chk("t2_lo_e1", 32'(lo), 32'h5555);
    step();
    chk("t2_busy_e2", 32'(busy), 32'd1);
    chk("t2_hi_e2", 32'(hi), 32'h0000);
    bus.mul_r = 32'h0000_5555;
    step();
    chk("t2_busy_e3", 32'(busy), 32'd0);
    chk("t2_hi", 32'(hi), 32'h0000);
    chk("t2_lo", 32'(lo), 32'h5555);
    bus.mul_valid = 1'b0;

    // 3: signed-model products
    run_mul(16'hFFFF, 16'd21845, 32'hFFFF_AAAB);
    run_mul(16'd10922, 16'd2, 32'h0000_5554);

    // 4: timeout, then err stays sticky
    launch(16'd7, 16'd9);
    wait_idle(200, n);
    chk("t4_busy_cycles", 32'(n), 32'd64);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_hi", 32'(hi), 32'h0000);
    chk("t4_lo", 32'(lo), 32'h5554);
    chk("t4_ctrl", 32'(bus.mul_ctrl), 32'h0);
    run_mul(16'd3, 16'd5, 32'h0000_000F);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // 5: mthi/mtlo in IDLE and while busy
    wr_hi = 1'b1; wr_data = 16'h1234;
    step();
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 16'hBEEF;
    step();
    wr_lo = 1'b0;
    chk("t5_hi", 32'(hi), 32'h1234);
    chk("t5_lo", 32'(lo), 32'hBEEF);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 16'h0F0F;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("t5_both_hi", 32'(hi), 32'h0F0F);
    chk("t5_both_lo", 32'(lo), 32'h0F0F);
    launch(16'hFFFF, 16'd21845);
    wr_hi = 1'b1; wr_data = 16'h1234;
    bus.mul_r = 32'hFFFF_AAAB; bus.mul_valid = 1'b1;
    #1;
    chk("t5_stall", 32'(stall), 32'd1);
    step();
    step();
    chk("t5_held_hi", 32'(hi), 32'h0F0F);
    chk("t5_held_stall", 32'(stall), 32'd1);
    step();
    chk("t5_prod_hi", 32'(hi), 32'hFFFF);
    chk("t5_prod_lo", 32'(lo), 32'hAAAB);
    chk("t5_stall_free", 32'(stall), 32'd0);
    step();
    chk("t5_late_hi", 32'(hi), 32'h1234);
    chk("t5_late_lo", 32'(lo), 32'hAAAB);
    wr_hi = 1'b0; bus.mul_valid = 1'b0;

    // 6: asynchronous reset in WAIT
    launch(16'd2, 16'd3);
    step();
    step();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_hi", 32'(hi), 32'h0000);
    chk("t6_lo", 32'(lo), 32'h0000);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ctrl", 32'(bus.mul_ctrl), 32'h0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_mul_a", 32'(bus.mul_a), 32'h0000);
    #2 rst_n = 1'b1;
    bus.mul_r = 32'h1234_5678; bus.mul_valid = 1'b1;
    step();
    step();
    bus.mul_valid = 1'b0;
    step();
    chk("t6_post_hi", 32'(hi), 32'h0000);
    chk("t6_post_lo", 32'(lo), 32'h0000);
    chk("t6_post_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
